// File: rtl/regfile_pkg.sv
// Shared constants and register-address type for the scoreboarded register file.
package regfile_pkg;

  localparam int unsigned DWIDTH_DEF = 32;
  localparam int unsigned NREGS_DEF  = 32;
  localparam int unsigned REG_AW     = $clog2(NREGS_DEF);

  typedef logic [REG_AW-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits tracking outstanding results, with the pending-count popcount.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEF,
  localparam int unsigned AW   = $clog2(NREGS),
  localparam int unsigned CW   = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_i,
  input  logic [AW-1:0]    set_idx_i,
  input  logic             clr_i,
  input  logic [AW-1:0]    clr_idx_i,
  output logic [NREGS-1:0] busy_o,
  output logic [CW-1:0]    pend_cnt_o
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [CW-1:0]    cnt;

  // Set is applied after clear so a same-edge re-issue keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (clr_i) busy_d[clr_idx_i] = 1'b0;
    if (set_i && (set_idx_i != '0)) busy_d[set_idx_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < NREGS; i++) cnt = cnt + CW'(busy_q[i]);
  end

  assign busy_o     = busy_q;
  assign pend_cnt_o = cnt;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with scoreboard; x0 hardwired to zero.
// Define REGFILE_SB_BYPASS_EN to forward same-cycle writeback data to the read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DWIDTH  = DWIDTH_DEF,
  parameter int unsigned NREGS   = NREGS_DEF,
  parameter int unsigned NRPORTS = 2,
  localparam int unsigned AW     = $clog2(NREGS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NRPORTS*AW-1:0]     rd_addr,
  output logic [NRPORTS*DWIDTH-1:0] rd_data,
  output logic [NRPORTS-1:0]        rd_busy,
  input  logic                      issue_valid,
  input  logic [AW-1:0]             issue_rd,
  input  logic                      issue_pend,
  input  logic                      wb_valid,
  input  logic [AW-1:0]             wb_rd,
  input  logic [DWIDTH-1:0]         wb_data,
  output logic                      stall,
  output logic [AW:0]               pend_cnt
);

  logic [DWIDTH-1:0] regs_q [NREGS];
  logic [NREGS-1:0]  busy;
  logic [AW-1:0]     rd_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wb_valid && (wb_rd != '0)) begin
      regs_q[wb_rd] <= wb_data;
    end
  end

  regfile_scoreboard #(.NREGS(NREGS)) u_sb (
    .clk        (clk),
    .reset      (reset),
    .set_i      (issue_valid && issue_pend),
    .set_idx_i  (issue_rd),
    .clr_i      (wb_valid),
    .clr_idx_i  (wb_rd),
    .busy_o     (busy),
    .pend_cnt_o (pend_cnt)
  );

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    rd_idx  = '0;
    for (int unsigned p = 0; p < NRPORTS; p++) begin
      rd_idx = rd_addr[p*AW +: AW];
      if (rd_idx != '0) begin
        rd_data[p*DWIDTH +: DWIDTH] = regs_q[rd_idx];
        rd_busy[p]                  = busy[rd_idx];
`ifdef REGFILE_SB_BYPASS_EN
        if (wb_valid && (wb_rd == rd_idx)) begin
          rd_data[p*DWIDTH +: DWIDTH] = wb_data;
          rd_busy[p]                  = 1'b0;
        end
`endif
      end
    end
  end

  assign stall = |rd_busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (4 read ports, 32 x 32-bit).
module tb_regfile_sb;
  import regfile_pkg::*;

  localparam int unsigned NP = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NP*5-1:0]   rd_addr;
  logic [NP*32-1:0]  rd_data;
  logic [NP-1:0]     rd_busy;
  logic              issue_valid, issue_pend, wb_valid;
  reg_addr_t         issue_rd, wb_rd;
  logic [31:0]       wb_data;
  logic              stall;
  logic [5:0]        pend_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_sb #(.DWIDTH(32), .NREGS(32), .NRPORTS(NP)) dut (
    .clk         (clk),
    .reset       (reset),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_pend  (issue_pend),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .stall       (stall),
    .pend_cnt    (pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setrd(input int p, input int a);
    rd_addr[p*5 +: 5] = 5'(a);
  endtask

  task automatic issue(input int r);
    issue_valid = 1'b1; issue_pend = 1'b1; issue_rd = 5'(r);
    tick();
    issue_valid = 1'b0; issue_pend = 1'b0;
  endtask

  task automatic wb(input int r, input logic [31:0] d);
    wb_valid = 1'b1; wb_rd = 5'(r); wb_data = d;
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int p = 0; p < int'(NP); p++) setrd(p, 5);
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (rd_data !== '0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    n_checks++; if (rd_busy !== 4'b0000) begin n_fail++; $display("FAIL reset_rd_busy: got %b want 0000", rd_busy); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_checks++; if (pend_cnt !== 6'd0) begin n_fail++; $display("FAIL reset_pend_cnt: got %0d want 0", pend_cnt); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    wb(7, 32'hDEADBEEF);
    setrd(0, 7);
    #1;
    n_checks++; if (rd_data[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_x7: got %h want deadbeef", rd_data[31:0]); end
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234;
    setrd(1, 0);
    #1;
    n_checks++; if (rd_data[63:32] !== 32'h0) begin n_fail++; $display("FAIL x0_during_wb: got %h want 0", rd_data[63:32]); end
    tick();
    wb_valid = 1'b0;
    #1;
    n_checks++; if (rd_data[63:32] !== 32'h0) begin n_fail++; $display("FAIL x0_after_wb: got %h want 0", rd_data[63:32]); end
    n_checks++; if (rd_busy[1] !== 1'b0) begin n_fail++; $display("FAIL x0_busy: got %b want 0", rd_busy[1]); end
  endtask

  task automatic test_pending();
    issue(3);
    setrd(0, 3); setrd(1, 3); setrd(2, 0); setrd(3, 0);
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL pend_stall: got %b want 1", stall); end
    n_checks++; if (pend_cnt !== 6'd1) begin n_fail++; $display("FAIL pend_cnt_one: got %0d want 1", pend_cnt); end
    n_checks++; if (rd_busy !== 4'b0011) begin n_fail++; $display("FAIL pend_rd_busy: got %b want 0011", rd_busy); end
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h55;
    #1;
`ifdef REGFILE_SB_BYPASS_EN
    n_checks++; if (rd_data[63:0] !== {32'h55, 32'h55}) begin n_fail++; $display("FAIL bypass_data: got %h want 55 on both", rd_data[63:0]); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL bypass_stall: got %b want 0", stall); end
`else
    n_checks++; if (rd_data[63:0] !== 64'h0) begin n_fail++; $display("FAIL nobypass_data: got %h want 0", rd_data[63:0]); end
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL nobypass_stall: got %b want 1", stall); end
`endif
    tick();
    wb_valid = 1'b0;
    #1;
    n_checks++; if (rd_data[31:0] !== 32'h55) begin n_fail++; $display("FAIL wb_x3_data: got %h want 55", rd_data[31:0]); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL wb_x3_stall: got %b want 0", stall); end
    n_checks++; if (pend_cnt !== 6'd0) begin n_fail++; $display("FAIL wb_x3_pend: got %0d want 0", pend_cnt); end
  endtask

  task automatic test_same_edge();
    issue_valid = 1'b1; issue_pend = 1'b1; issue_rd = 5'd9;
    wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'hAA;
    setrd(0, 9); setrd(1, 0);
    tick();
    issue_valid = 1'b0; issue_pend = 1'b0; wb_valid = 1'b0;
    #1;
    n_checks++; if (rd_data[31:0] !== 32'hAA) begin n_fail++; $display("FAIL same_edge_data: got %h want aa", rd_data[31:0]); end
    n_checks++; if (rd_busy[0] !== 1'b1) begin n_fail++; $display("FAIL same_edge_busy: got %b want 1", rd_busy[0]); end
    n_checks++; if (pend_cnt !== 6'd1) begin n_fail++; $display("FAIL same_edge_pend: got %0d want 1", pend_cnt); end
    wb(9, 32'hAB);
    #1;
    n_checks++; if (pend_cnt !== 6'd0) begin n_fail++; $display("FAIL same_edge_clear: got %0d want 0", pend_cnt); end
  endtask

  task automatic test_waw_and_plain();
    issue(6);
    issue(6);
    #1;
    n_checks++; if (pend_cnt !== 6'd1) begin n_fail++; $display("FAIL waw_pend: got %0d want 1", pend_cnt); end
    issue_valid = 1'b1; issue_pend = 1'b0; issue_rd = 5'd8;
    tick();
    issue_valid = 1'b0;
    setrd(0, 8);
    #1;
    n_checks++; if (rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL nopend_busy: got %b want 0", rd_busy[0]); end
    n_checks++; if (pend_cnt !== 6'd1) begin n_fail++; $display("FAIL nopend_cnt: got %0d want 1", pend_cnt); end
    wb(10, 32'h77);
    setrd(0, 10);
    #1;
    n_checks++; if (rd_data[31:0] !== 32'h77) begin n_fail++; $display("FAIL plain_wb_data: got %h want 77", rd_data[31:0]); end
    n_checks++; if (pend_cnt !== 6'd1) begin n_fail++; $display("FAIL plain_wb_pend: got %0d want 1", pend_cnt); end
    issue(0);
    #1;
    n_checks++; if (pend_cnt !== 6'd1) begin n_fail++; $display("FAIL issue_x0_pend: got %0d want 1", pend_cnt); end
    wb(6, 32'h66);
    #1;
    n_checks++; if (pend_cnt !== 6'd0) begin n_fail++; $display("FAIL waw_clear: got %0d want 0", pend_cnt); end
  endtask

  task automatic test_four_ports();
    issue(4);
    for (int p = 0; p < int'(NP); p++) setrd(p, 4);
    #1;
    n_checks++; if (rd_busy !== 4'b1111) begin n_fail++; $display("FAIL four_busy: got %b want 1111", rd_busy); end
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL four_stall: got %b want 1", stall); end
    setrd(0, 7); setrd(1, 9); setrd(2, 4); setrd(3, 0);
    #1;
    n_checks++; if (rd_busy !== 4'b0100) begin n_fail++; $display("FAIL mixed_busy: got %b want 0100", rd_busy); end
    n_checks++; if (rd_data !== {32'h0, 32'h0, 32'hAB, 32'hDEADBEEF}) begin n_fail++; $display("FAIL mixed_data: got %h want 0/0/ab/deadbeef", rd_data); end
    wb(4, 32'h44);
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL four_clear_stall: got %b want 0", stall); end
  endtask

  task automatic test_reset_mid();
    issue(1);
    issue(2);
    issue(3);
    setrd(0, 1); setrd(1, 7); setrd(2, 0); setrd(3, 0);
    #1;
    n_checks++; if (pend_cnt !== 6'd3) begin n_fail++; $display("FAIL three_pend: got %0d want 3", pend_cnt); end
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL three_stall: got %b want 1", stall); end
    #1 reset = 1'b1;
    #1;
    n_checks++; if (pend_cnt !== 6'd0) begin n_fail++; $display("FAIL async_rst_pend: got %0d want 0", pend_cnt); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL async_rst_stall: got %b want 0", stall); end
    n_checks++; if (rd_data[63:32] !== 32'h0) begin n_fail++; $display("FAIL async_rst_data: got %h want 0", rd_data[63:32]); end
    reset = 1'b0;
    tick();
    wb(2, 32'h99);
    setrd(0, 2);
    #1;
    n_checks++; if (rd_data[31:0] !== 32'h99) begin n_fail++; $display("FAIL post_rst_wb: got %h want 99", rd_data[31:0]); end
    n_checks++; if (pend_cnt !== 6'd0) begin n_fail++; $display("FAIL post_rst_pend: got %0d want 0", pend_cnt); end
  endtask

  initial begin
    reset = 1'b1; rd_addr = '0;
    issue_valid = 1'b0; issue_pend = 1'b0; issue_rd = '0;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    test_reset();
    test_write_read();
    test_pending();
    test_same_edge();
    test_waw_and_plain();
    test_four_ports();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter NREGS, default 32, number of architectural registers (power of 2, >=2).
REQ-003 SHALL have parameter NRPORTS, default 2, number of independent read ports (1..4).
REQ-004 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port rd_addr  in  NRPORTS x $clog2(NREGS)  read addresses, port p in slice p.
REQ-007 SHALL have port rd_data  out  NRPORTS x DWIDTH  read data per port.
REQ-008 SHALL have port rd_busy  out  NRPORTS  per-port flag: read register has an outstanding result.
REQ-009 SHALL have ports issue_valid  in  1, issue_rd  in  $clog2(NREGS), issue_pend  in  1: instruction issue, destination, result arrives later (e.g. load).
REQ-010 SHALL have ports wb_valid  in  1, wb_rd  in  $clog2(NREGS), wb_data  in  DWIDTH: writeback request.
REQ-011 SHALL have port stall  out  1  OR of rd_busy over all ports.
REQ-012 SHALL have port pend_cnt  out  $clog2(NREGS)+1  count of set busy bits.

Function
REQ-013 SHALL write wb_data to register wb_rd on rising clk when wb_valid=1 and wb_rd!=0.
REQ-014 SHALL hold register 0 at zero; reads of address 0 return 0, rd_busy=0, writes/issues to 0 ignored.
REQ-015 SHALL provide combinational (zero-latency) reads on every port independently; identical addresses on several ports allowed.
REQ-016 SHALL keep one busy bit per register; set on rising clk when issue_valid=1, issue_pend=1, issue_rd!=0.
REQ-017 SHALL clear busy[wb_rd] on rising clk when wb_valid=1.
REQ-018 SHALL, on same-edge set and clear of one register, leave busy set (newer issue wins).
REQ-019 SHALL accept issue to an already-busy register (WAW); busy stays set, no count change.
REQ-020 SHALL drive rd_busy[p] = busy[rd_addr[p]], except as modified by REQ-030.
REQ-021 SHALL compute pend_cnt combinationally as popcount of busy vector; range 0..NREGS-1.
REQ-022 SHALL ignore issue_valid with issue_pend=0 (no state change).
REQ-023 SHALL treat wb_valid to a non-busy register as a plain write (no error, busy unchanged).

Reset
REQ-024 SHALL, while reset=1, asynchronously clear all registers to 0 and all busy bits to 0.
REQ-025 SHALL, during/after reset, drive rd_data=0, rd_busy=0, stall=0, pend_cnt=0 until new writes/issues.
REQ-026 SHALL discard all outstanding results on reset mid-operation; a later wb_valid is a plain write.

Configuration
REQ-027 SHALL support macro REGFILE_SB_BYPASS_EN selecting write-to-read bypass.
REQ-028 SHALL, with REGFILE_SB_BYPASS_EN defined, return wb_data on any port with wb_valid=1 and rd_addr[p]==wb_rd!=0 in the same cycle.
REQ-029 SHALL, without the macro, return the stored (pre-write) value in that cycle.
REQ-030 SHALL, with the macro defined, force rd_busy[p]=0 when the same-cycle writeback targets rd_addr[p]; without it rd_busy[p] follows busy bit (stall one extra cycle).

Structure
REQ-031 SHALL place shared constants (default DWIDTH, NREGS, register-address width) and the register-address typedef in package regfile_pkg.
REQ-032 SHALL implement the busy vector, set/clear priority and popcount in sub-module regfile_scoreboard; storage and read muxing remain in regfile_sb.

Verification
REQ-033 SHALL cover: reset, then read x5 on both ports -> rd_data=0, stall=0, pend_cnt=0.
REQ-034 SHALL cover: wb x7=0xDEADBEEF, next cycle read x7 -> 0xDEADBEEF; wb x0=0x1234 -> x0 reads 0.
REQ-035 SHALL cover: issue_pend x3, read x3 -> stall=1, pend_cnt=1; wb x3=0x55 -> with bypass same-cycle rd_data=0x55, stall=0; without bypass rd_data=old, stall=1, next cycle 0x55, stall=0.
REQ-036 SHALL cover: same edge issue_pend x9 and wb x9=0xAA -> x9 reads 0xAA, busy[9]=1, pend_cnt=1.
REQ-037 SHALL cover: issue_pend x1,x2,x3 -> pend_cnt=3; assert reset mid-sequence -> pend_cnt=0, stall=0 immediately (asynchronous).
REQ-038 SHALL cover: NRPORTS=4, all ports rd_addr=x4 busy -> rd_busy=4'b1111, stall=1.
